// File: rtl/imem_pkg.sv
// Shared fault codes and address decode for the instruction memory fetch and load paths.
package imem_pkg;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_RANGE    = 2'b01,
    FAULT_MISALIGN = 2'b10
  } fault_e;

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input bit byte_addr);
    return byte_addr ? (addr >> 2) : addr;
  endfunction

  // The full-width index is compared so oversized addresses never alias into the array.
  function automatic fault_e addr_fault(input logic [63:0] addr, input logic [63:0] depth,
                                        input bit byte_addr);
    if (byte_addr && (addr[1:0] != 2'b00)) return FAULT_MISALIGN;
    if (addr_index(addr, byte_addr) >= depth) return FAULT_RANGE;
    return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch request/response handshake between the PC stage (master) and the instruction memory (slave).
interface imem_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [1:0]        rsp_fault;

  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_instr, rsp_fault);
  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_instr, rsp_fault);
endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W synchronous RAM, one read and one write port, read-before-write on collision.
module imem_array #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int               IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};
  logic [DATA_W-1:0] rd_data_q;

  // Both ports update with non-blocking writes, so a same-index read sees the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_idx];
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a single-stage registered fetch port, fault reporting and a program-load port.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 32,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imem_fetch_unit_if.slave   fetch_if,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_err,
  output logic [15:0]        fetch_cnt
);
  localparam int IDX_W = $clog2(DEPTH);

  fault_e            req_fault, load_fault;
  logic [IDX_W-1:0]  req_idx, load_idx;
  logic              accept;
  logic [DATA_W-1:0] ram_rdata;

  logic   rsp_valid_q, rsp_valid_d;
  fault_e fault_q, fault_d;
  logic   nop_q, nop_d;
  logic   load_err_q, load_err_d;
  logic [15:0] cnt_q, cnt_d;

  assign req_fault  = addr_fault(64'(fetch_if.req_addr), 64'(DEPTH), BYTE_ADDR != 0);
  assign load_fault = addr_fault(64'(load_addr), 64'(DEPTH), BYTE_ADDR != 0);
  assign req_idx    = IDX_W'(addr_index(64'(fetch_if.req_addr), BYTE_ADDR != 0));
  assign load_idx   = IDX_W'(addr_index(64'(load_addr), BYTE_ADDR != 0));

  assign fetch_if.req_ready = !flush && (!rsp_valid_q || fetch_if.rsp_ready);
  assign accept             = fetch_if.req_valid && fetch_if.req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    fault_d     = fault_q;
    nop_d       = nop_q;
    cnt_d       = cnt_q;
    load_err_d  = load_en && (load_fault != FAULT_OK);
    if (accept) begin
      rsp_valid_d = 1'b1;
      fault_d     = req_fault;
      nop_d       = (req_fault != FAULT_OK);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (flush || fetch_if.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // nop_q resets high so the instruction output reads NOP_WORD out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      fault_q     <= FAULT_OK;
      nop_q       <= 1'b1;
      load_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      nop_q       <= nop_d;
      load_err_q  <= load_err_d;
      cnt_q       <= cnt_d;
    end
  end

  imem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP_WORD)
  ) u_array (
    .clk    (clk),
    .rd_en  (accept),
    .rd_idx (req_idx),
    .rd_data(ram_rdata),
    .wr_en  (load_en && (load_fault == FAULT_OK)),
    .wr_idx (load_idx),
    .wr_data(load_data)
  );

  assign fetch_if.rsp_valid = rsp_valid_q;
  assign fetch_if.rsp_instr = nop_q ? NOP_WORD : ram_rdata;
  assign fetch_if.rsp_fault = fault_q;
  assign load_err           = load_err_q;
  assign fetch_cnt          = cnt_q;
endmodule
